// File: rtl/adder_bist_n.sv
// Purpose: WIDTH-bit adder with LFSR/MISR built-in self-test, with golden-signature compare or learn.
// Latency: adder is combinational; a BIST run reports done/error N_PATTERNS+1 clocks after start.
// Backpressure: none; test_mode must stay high for the whole run, and dropping it aborts the run.
module adder_bist_n #(
  parameter int               WIDTH      = 4,
  parameter int               N_PATTERNS = 511,
  parameter logic [2*WIDTH:0] LFSR_SEED  = 9'h001,
  parameter logic [2*WIDTH:0] LFSR_TAPS  = 9'h110,
  parameter logic [WIDTH:0]   MISR_TAPS  = 5'h14,
  parameter logic [WIDTH:0]   GOLDEN     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             test_mode,
  input  logic             learn,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             done,
  output logic             error,
  output logic [WIDTH:0]   signature
);

  localparam int L  = 2 * WIDTH + 1;
  localparam int M  = WIDTH + 1;
  localparam int CW = $clog2(N_PATTERNS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_PATTERNS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    lfsr_q, lfsr_d;
  logic [M-1:0]    misr_q, misr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [M-1:0]    golden_q, golden_d;
  logic            learn_q, learn_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  // Adder stimulus nets; kept as separate named nets so they can be overridden from outside.
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             mux_cin;

  logic [M-1:0]     add_result;
  logic [L-1:0]     lfsr_next;
  logic [M-1:0]     misr_next;

  // The LFSR only owns the adder while a run is in progress.
  assign mux_a   = (state_q == ST_RUN) ? lfsr_q[WIDTH-1:0]       : a;
  assign mux_b   = (state_q == ST_RUN) ? lfsr_q[2*WIDTH-1:WIDTH] : b;
  assign mux_cin = (state_q == ST_RUN) ? lfsr_q[2*WIDTH]         : c_in;

  // Carry out lands in the top bit of the widened sum.
  assign add_result = {1'b0, mux_a} + {1'b0, mux_b} + {{WIDTH{1'b0}}, mux_cin};
  assign sum        = add_result[WIDTH-1:0];
  assign c_out      = add_result[WIDTH];

  // Fibonacci-style shift with parity feedback, for both the pattern source and the compactor.
  assign lfsr_next = {lfsr_q[L-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign misr_next = {misr_q[M-2:0], ^(misr_q & MISR_TAPS)} ^ add_result;

  assign done      = done_q;
  assign error     = error_q;
  assign signature = misr_q;

  // Next-state logic: every register holds unless the current state says otherwise.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    count_d  = count_q;
    golden_d = golden_q;
    learn_d  = learn_q;
    done_d   = done_q;
    error_d  = error_q;

    case (state_q)
      ST_IDLE: begin
        if (test_mode) begin
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          count_d = '0;
          learn_d = learn;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // An abort wins over everything, including the final-pattern transition into CHECK.
        if (!test_mode) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          misr_d  = misr_next;
          lfsr_d  = lfsr_next;
          count_d = count_q + CW'(1);
          if (count_q == LAST_CNT) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (learn_q) begin
          golden_d = misr_q;
          error_d  = 1'b0;
        end else begin
          error_d  = (misr_q != golden_q);
        end
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Result stays visible after leaving; a new run needs test_mode low for an edge first.
        if (!test_mode) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      misr_q   <= '0;
      count_q  <= '0;
      golden_q <= GOLDEN;
      learn_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      count_q  <= count_d;
      golden_q <= golden_d;
      learn_q  <= learn_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_adder_bist_n.sv
// Purpose: self-checking bench for adder_bist_n (511-pattern instance plus a 1-pattern instance).
// Latency: checks done latency of N_PATTERNS+1 clocks after run start.
// Backpressure: none; stimulus drives test_mode/learn directly.
module tb_adder_bist_n;

  localparam int N = 511;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] a, b;
  logic       c_in, test_mode, learn, tm1, learn1;
  logic [3:0] sum, sum1;
  logic       c_out, c_out1, done, done1, error, error1;
  logic [4:0] signature, signature1;

  always #5 clock = ~clock;

  adder_bist_n #(.WIDTH(4), .N_PATTERNS(N)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .c_in(c_in),
    .test_mode(test_mode), .learn(learn), .sum(sum), .c_out(c_out),
    .done(done), .error(error), .signature(signature)
  );

  adder_bist_n #(.WIDTH(4), .N_PATTERNS(1)) dut1 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c_in(c_in),
    .test_mode(tm1), .learn(learn1), .sum(sum1), .c_out(c_out1),
    .done(done1), .error(error1), .signature(signature1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the block's defining equations.
  function automatic logic [8:0] lfsr_step(input logic [8:0] l);
    return {l[7:0], ^(l & 9'h110)};
  endfunction

  function automatic logic [4:0] misr_step(input logic [4:0] m, input logic [4:0] r);
    return {m[3:0], ^(m & 5'h14)} ^ r;
  endfunction

  function automatic logic [4:0] add5(input logic [3:0] x, input logic [3:0] y, input logic ci,
                                      input bit stuck_b0);
    logic [3:0] yy;
    yy = y;
    if (stuck_b0) yy[0] = 1'b0;
    return {1'b0, x} + {1'b0, yy} + {4'b0, ci};
  endfunction

  // Full-run signature from the seed, optionally with operand b bit 0 stuck low.
  function automatic logic [4:0] misr_ref(input int n, input bit stuck_b0);
    logic [8:0] l;
    logic [4:0] m;
    l = 9'h001;
    m = 5'h00;
    for (int i = 0; i < n; i++) begin
      m = misr_step(m, add5(l[3:0], l[7:4], l[8], stuck_b0));
      l = lfsr_step(l);
    end
    return m;
  endfunction

  // Behavioural model of the 511-pattern instance: phase 0 idle, 1 running, 2 checking, 3 finished.
  logic [8:0] pat [0:N-1];
  int         ph     = 0;
  int         k      = 0;
  logic [4:0] m_sig  = 5'h00;
  logic [4:0] m_gold = 5'h00;
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;
  bit         m_lq   = 1'b0;
  bit         fault  = 1'b0;
  bit         cmp_en = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph <= 0; k <= 0; m_sig <= 5'h00; m_gold <= 5'h00;
      m_done <= 1'b0; m_err <= 1'b0; m_lq <= 1'b0;
    end else begin
      case (ph)
        0: if (test_mode) begin
             ph <= 1; k <= 0; m_sig <= 5'h00; m_lq <= learn;
             m_done <= 1'b0; m_err <= 1'b0;
           end
        1: if (!test_mode) begin
             ph <= 0; m_done <= 1'b0; m_err <= 1'b0;
           end else begin
             m_sig <= misr_step(m_sig, add5(pat[k][3:0], pat[k][7:4], pat[k][8], fault));
             k <= k + 1;
             if (k == N - 1) ph <= 2;
           end
        2: begin
             if (m_lq) begin
               m_gold <= m_sig; m_err <= 1'b0;
             end else begin
               m_err <= (m_sig != m_gold);
             end
             m_done <= 1'b1;
             ph <= 3;
           end
        default: if (!test_mode) ph <= 0;
      endcase
    end
  end

  function automatic logic [4:0] model_res();
    if (ph == 1) return add5(pat[k][3:0], pat[k][7:4], pat[k][8], fault);
    return add5(a, b, c_in, fault);
  endfunction

  // Per-cycle comparison of every main-instance output against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_result", 32'({c_out, sum}), 32'(model_res()));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_error", 32'(error), 32'(m_err));
      check("cyc_signature", 32'(signature), 32'(m_sig));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Caller has already raised test_mode; returns edge index (E0 = 0) where done is first seen.
  task automatic time_run(input bit which, output int lat);
    lat = -1;
    for (int j = 0; j < 2000; j++) begin
      @(posedge clock);
      #1;
      if ((which ? done1 : done) === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  int         lat;
  logic [4:0] sig_learn;

  initial begin
    reset = 1'b0; a = 4'h5; b = 4'hA; c_in = 1'b0;
    test_mode = 1'b0; learn = 1'b0; tm1 = 1'b0; learn1 = 1'b0;
    begin
      logic [8:0] l;
      l = 9'h001;
      for (int i = 0; i < N; i++) begin
        pat[i] = l;
        l = lfsr_step(l);
      end
    end
    #1 cmp_en = 1'b1;

    // Hand-derived signatures after 1, 3 and 5 patterns from seed 9'h001.
    check("pin_misr1", 32'(misr_ref(1, 1'b0)), 32'h01);
    check("pin_misr3", 32'(misr_ref(3, 1'b0)), 32'h04);
    check("pin_misr5", 32'(misr_ref(5, 1'b0)), 32'h03);

    #1;
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_signature", 32'(signature), 32'h0);
    check("rst_result", 32'({c_out, sum}), 32'h0F);

    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Functional path.
    check("func_cin0", 32'({c_out, sum}), 32'h0F);
    c_in = 1'b1;
    #1 check("func_cin1", 32'({c_out, sum}), 32'h10);
    c_in = 1'b0;

    // Reset in the middle of a run.
    tick();
    test_mode = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("otf_done", 32'(done), 32'h0);
    check("otf_error", 32'(error), 32'h0);
    check("otf_signature", 32'(signature), 32'h0);
    check("otf_result", 32'({c_out, sum}), 32'h0F);
    test_mode = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Learn run.
    learn = 1'b1; test_mode = 1'b1;
    time_run(1'b0, lat);
    learn = 1'b0;
    check("learn_latency", 32'(lat), 32'(N + 1));
    check("learn_error", 32'(error), 32'h0);
    check("learn_signature", 32'(signature), 32'(misr_ref(N, 1'b0)));
    sig_learn = signature;

    // Fault-free compare run.
    test_mode = 1'b0; tick(); test_mode = 1'b1;
    time_run(1'b0, lat);
    check("cmp_latency", 32'(lat), 32'(N + 1));
    check("cmp_error", 32'(error), 32'h0);
    check("cmp_signature", 32'(signature), 32'(sig_learn));

    // Stuck-at-0 on operand b bit 0.
    test_mode = 1'b0;
    force dut.mux_b[0] = 1'b0;
    fault = 1'b1;
    tick(); test_mode = 1'b1;
    time_run(1'b0, lat);
    check("fault_latency", 32'(lat), 32'(N + 1));
    check("fault_error", 32'(error), 32'h1);
    check("fault_sig_differs", 32'(signature != sig_learn), 32'h1);
    check("fault_signature", 32'(signature), 32'(misr_ref(N, 1'b1)));

    test_mode = 1'b0;
    release dut.mux_b[0];
    fault = 1'b0;
    tick(); test_mode = 1'b1;
    time_run(1'b0, lat);
    check("rerun_error", 32'(error), 32'h0);
    check("rerun_done", 32'(done), 32'h1);
    test_mode = 1'b0;
    tick();

    // Single-pattern instance: latency, learn, abort at the last absorb edge, then a clean run.
    learn1 = 1'b1; tm1 = 1'b1;
    time_run(1'b1, lat);
    learn1 = 1'b0;
    check("n1_latency", 32'(lat), 32'h2);
    check("n1_error", 32'(error1), 32'h0);
    check("n1_signature", 32'(signature1), 32'h01);

    tm1 = 1'b0; tick(); tm1 = 1'b1;
    tick();          // E0
    tm1 = 1'b0;
    tick();          // E1 sees test_mode low
    check("n1_abort_done", 32'(done1), 32'h0);
    tick();
    check("n1_abort_done_later", 32'(done1), 32'h0);
    check("n1_abort_error", 32'(error1), 32'h0);

    tm1 = 1'b1;
    time_run(1'b1, lat);
    check("n1_rerun_latency", 32'(lat), 32'h2);
    check("n1_rerun_error", 32'(error1), 32'h0);
    check("n1_rerun_signature", 32'(signature1), 32'h01);
    tm1 = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
